// File: rtl/ysyx_22040386_muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative mul/div sequencer.
interface ysyx_22040386_muldiv_seq_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_op;
  logic            i_Word_op;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            i_flush;
  logic            o_busy;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_Word_op, i_src1, i_src2, i_flush, i_out_ready,
    input  o_ready, o_busy, o_out_valid, o_result
  );
  modport slave (
    input  i_valid, i_op, i_Word_op, i_src1, i_src2, i_flush, i_out_ready,
    output o_ready, o_busy, o_out_valid, o_result
  );
endinterface

// File: rtl/ysyx_22040386_muldiv_seq.sv
// Iterative RV64M sequencer: shift-add multiply and restoring divide on one shared datapath.
// Optional macro YSYX_22040386_MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | ready to accept a request
// CALC  | one iteration per cycle; at count 0 the sign/Word fix-up is registered
// DONE  | result held until taken or flushed
module ysyx_22040386_muldiv_seq #(
  parameter int XLEN = 64
) (
  input logic                       clk,
  input logic                       rst_n,
  ysyx_22040386_muldiv_seq_if.slave bus
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d, neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d;

  logic            accept, is_div, sgn1, sgn2, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_min, spec_res;

  always_comb begin
    accept = bus.i_valid & (state_q == S_IDLE) & ~bus.i_flush;
    is_div = bus.i_op[2];
    // Word multiplies are plain MULW, so no operand is treated as signed
    sgn1   = (~bus.i_Word_op & ((bus.i_op == 3'b001) | (bus.i_op == 3'b010))) | (is_div & ~bus.i_op[0]);
    sgn2   = (~bus.i_Word_op & (bus.i_op == 3'b001)) | (is_div & ~bus.i_op[0]);
    a_ext  = bus.i_src1;
    b_ext  = bus.i_src2;
    a_min  = {1'b1, {(XLEN-1){1'b0}}};
    if (bus.i_Word_op) begin
      a_ext = {{HW{sgn1 & bus.i_src1[HW-1]}}, bus.i_src1[HW-1:0]};
      b_ext = {{HW{sgn2 & bus.i_src2[HW-1]}}, bus.i_src2[HW-1:0]};
      a_min = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
    end
    a_neg    = sgn1 & a_ext[XLEN-1];
    b_neg    = sgn2 & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = is_div & (b_ext == '0);
    div_ovf  = is_div & sgn1 & (a_ext == a_min) & (b_ext == '1);
    spec_res = '1;
    if (bus.i_op[1])
      spec_res = bus.i_Word_op ? {{HW{bus.i_src1[HW-1]}}, bus.i_src1[HW-1:0]} : bus.i_src1;
    if (div_ovf)
      spec_res = bus.i_op[1] ? '0 : a_ext;
  end

  logic [XLEN:0]     mul_sum, rem_sh, div_trial;
  logic [2*XLEN-1:0] acc_it, mul_full, mul_fix;
  logic [XLEN-1:0]   quo, rem, raw_res, fin_res;
  logic [CW-1:0]     cnt_it;

  always_comb begin
    cnt_it    = cnt_q - CW'(1);
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    rem_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = rem_sh - {1'b0, opb_q};
    if (op_q[2])
      acc_it = div_trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_it = {mul_sum, acc_q[XLEN-1:1]};
    // Word multiplies only run HW shifts, leaving the product HW bits up
    mul_full = word_q ? (acc_q >> HW) : acc_q;
    mul_fix  = neg_q ? -mul_full : mul_full;
    quo      = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem      = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])
      raw_res = op_q[1] ? rem : quo;
    else if (word_q || (op_q[1:0] == 2'b00))
      raw_res = mul_fix[XLEN-1:0];
    else
      raw_res = mul_fix[2*XLEN-1:XLEN];
    fin_res = word_q ? {{HW{raw_res[HW-1]}}, raw_res[HW-1:0]} : raw_res;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = bus.i_op;
          word_d  = bus.i_Word_op;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          spec_d  = div_zero | div_ovf;
          state_d = S_CALC;
          if (div_zero | div_ovf) begin
            // special result is known now; a single count-0 pass gives it a one-cycle latency
            res_d = spec_res;
            cnt_d = '0;
          end else begin
            cnt_d = bus.i_Word_op ? CW'(HW) : CW'(XLEN);
            if (is_div) begin
              acc_d = {{XLEN{1'b0}}, (bus.i_Word_op ? {a_mag[HW-1:0], {HW{1'b0}}} : a_mag)};
              opb_d = b_mag;
            end else begin
              acc_d = {{XLEN{1'b0}}, b_mag};
              opb_d = a_mag;
            end
          end
        end
      end
      S_CALC: begin
        if (cnt_q == '0) begin
          if (!spec_q) res_d = fin_res;
          state_d = S_DONE;
        end else begin
          acc_d = acc_it;
          cnt_d = cnt_it;
`ifdef YSYX_22040386_MULDIV_EARLY_OUT_EN
          if (!op_q[2] && ((acc_it[XLEN-1:0] << (XLEN - int'(cnt_it))) == '0)) begin
            acc_d = acc_it >> cnt_it;
            cnt_d = '0;
          end
`endif
        end
      end
      S_DONE: begin
        if (bus.i_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.i_flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
    end
  end

  assign bus.o_ready     = (state_q == S_IDLE);
  assign bus.o_busy      = (state_q != S_IDLE);
  assign bus.o_out_valid = (state_q == S_DONE);
  assign bus.o_result    = res_q;
endmodule

// File: tb/tb_ysyx_22040386_muldiv_seq.sv
// Self-checking bench for the mul/div sequencer: directed cases plus random ops against an arithmetic model.
module tb_ysyx_22040386_muldiv_seq;
  localparam int XLEN = 64;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ysyx_22040386_muldiv_seq_if #(.XLEN(XLEN)) bus ();
  ysyx_22040386_muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result computed with plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] op, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]    p;
    logic [63:0]     r;
    longint          sa, sb;
    int              swa, swb;
    logic [31:0]     uwa, uwb;
    if (!op[2]) begin
      if (w) begin
        p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
        r = sx32(p[31:0]);
      end else begin
        case (op[1:0])
          2'b00:   begin p = {64'b0, a} * {64'b0, b};             r = p[63:0];   end
          2'b01:   begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
          2'b10:   begin p = {{64{a[63]}}, a} * {64'b0, b};       r = p[127:64]; end
          default: begin p = {64'b0, a} * {64'b0, b};             r = p[127:64]; end
        endcase
      end
    end else if (w) begin
      uwa = a[31:0];
      uwb = b[31:0];
      swa = uwa;
      swb = uwb;
      if (uwb == 32'd0)
        r = op[1] ? sx32(uwa) : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!op[0] && uwa == 32'h8000_0000 && uwb == 32'hFFFF_FFFF)
        r = op[1] ? 64'd0 : sx32(uwa);
      else if (!op[0])
        r = op[1] ? sx32(swa % swb) : sx32(swa / swb);
      else
        r = op[1] ? sx32(uwa % uwb) : sx32(uwa / uwb);
    end else begin
      sa = a;
      sb = b;
      if (b == 64'd0)
        r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        r = op[1] ? 64'd0 : a;
      else if (!op[0])
        r = op[1] ? sa % sb : sa / sb;
      else
        r = op[1] ? a % b : a / b;
    end
    return r;
  endfunction

  function automatic int lat(input logic [2:0] op, input logic w,
                             input logic [63:0] a, input logic [63:0] b);
    logic spec;
    spec = 1'b0;
    if (op[2]) begin
      if (w)
        spec = (b[31:0] == 32'd0) ||
               (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
      else
        spec = (b == 64'd0) ||
               (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    if (spec) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return 64'hFFFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return {32'h0, $urandom};
      5:       return 64'hFFFF_FFFF_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.i_op      = op;
    bus.i_Word_op = w;
    bus.i_src1    = a;
    bus.i_src2    = b;
    bus.i_valid   = 1'b1;
    chk("ready_before_accept", bus.o_ready, 64'd1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    chk("busy_after_accept", bus.o_busy, 64'd1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.o_out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input int hold);
    int cyc;
    issue(op, w, a, b);
    wait_valid(cyc);
    chk({tag, "_valid"}, bus.o_out_valid, 64'd1);
`ifdef YSYX_22040386_MULDIV_EARLY_OUT_EN
    if (!op[2]) chk({tag, "_lat_range"}, (cyc >= 2 && cyc <= exp_lat), 64'd1);
    else        chk({tag, "_lat"}, cyc, exp_lat);
`else
    chk({tag, "_lat"}, cyc, exp_lat);
`endif
    chk({tag, "_res"}, bus.o_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_op    = 3'($urandom_range(0, 7));
      bus.i_src1  = rnd64();
      bus.i_src2  = rnd64();
      chk({tag, "_hold_ready"}, bus.o_ready, 64'd0);
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, bus.o_out_valid, 64'd1);
      chk({tag, "_hold_res"}, bus.o_result, exp);
    end
    @(negedge clk);
    bus.i_valid     = 1'b0;
    bus.i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_out_ready = 1'b0;
    chk({tag, "_retire_ready"}, bus.o_ready, 64'd1);
    chk({tag, "_retire_valid"}, bus.o_out_valid, 64'd0);
  endtask

  initial begin
    int          cyc;
    logic        seen;
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b;

    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_op        = 3'b000;
    bus.i_Word_op   = 1'b0;
    bus.i_src1      = 64'd0;
    bus.i_src2      = 64'd0;
    bus.i_flush     = 1'b0;
    bus.i_out_ready = 1'b0;
    #2;
    chk("rst_ready", bus.o_ready, 64'd1);
    chk("rst_busy", bus.o_busy, 64'd0);
    chk("rst_valid", bus.o_out_valid, 64'd0);
    chk("rst_result", bus.o_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("mulhu_ones", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 65, 0);
    do_op("div_m7_2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    do_op("rem_m7_2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("divuw_by0", 3'b101, 1'b1, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    do_op("remw_by0", 3'b110, 1'b1, 64'd5, 64'd0, 64'd5, 1, 0);
    do_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1, 0);
    do_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
    do_op("mulh_neg", 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    do_op("mulw_bp", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 5);

    // asynchronous reset in the middle of a multiply
    issue(3'b011, 1'b0, 64'hFFFF_0000_1111_2222, 64'd3);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus.o_ready, 64'd1);
    chk("midrst_busy", bus.o_busy, 64'd0);
    chk("midrst_valid", bus.o_out_valid, 64'd0);
    chk("midrst_result", bus.o_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.o_out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 64'd0);

    // flush at cycle 10 of a multiply
    issue(3'b000, 1'b0, 64'h1234_5678_9ABC_DEF1, 64'h0FED_CBA9_8765_4321);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("flush_busy", bus.o_busy, 64'd0);
    chk("flush_ready", bus.o_ready, 64'd1);
    chk("flush_valid", bus.o_out_valid, 64'd0);
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1;
      if (bus.o_out_valid) seen = 1'b1;
    end
    chk("flush_no_result", seen, 64'd0);

    // flush together with a request blocks the accept
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op    = 3'b101;
    bus.i_src1  = 64'd40;
    bus.i_src2  = 64'd3;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    chk("flush_blocks_accept", bus.o_busy, 64'd0);

    // flush while a result is waiting
    issue(3'b101, 1'b1, 64'd9, 64'd0);
    wait_valid(cyc);
    chk("flush_done_pre", bus.o_out_valid, 64'd1);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    chk("flush_done_valid", bus.o_out_valid, 64'd0);
    chk("flush_done_ready", bus.o_ready, 64'd1);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      w  = 1'($urandom_range(0, 1));
      a  = rnd64();
      b  = rnd64();
      do_op("rnd", op, w, a, b, model(op, w, a, b), lat(op, w, a, b), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
